// File: rtl/exu_bp_upd_ctl_pkg.sv
// Shared types and helpers for the branch-predictor update queue.
// Holds the resolved-branch packet layout, the default depth and the BHT index hash.
package exu_bp_upd_ctl_pkg;

  localparam int BP_Q_DEPTH = 4;

  typedef struct packed {
    logic [31:1] pc;
    logic        ataken;
    logic        misp;
    logic [1:0]  hist;
  } bp_upd_pkt_t;

  // Folds pc[idx_w:1] with pc[2*idx_w:idx_w+1]; caller truncates to idx_w bits.
  function automatic logic [31:0] bht_hash(input logic [31:1] pc, input int unsigned idx_w);
    logic [31:0] p;
    p = {pc, 1'b0};
    return ((p >> 1) ^ (p >> (idx_w + 1))) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/exu_bp_upd_ctl_if.sv
// Bus bundles for the update queue: resolved-branch input side and BHT write side.
// Master is the producer of the valid/data signals on each bus.
interface exu_bp_upd_if;
  logic        upd_valid;
  logic [31:1] upd_pc;
  logic        upd_ataken;
  logic        upd_misp;
  logic [1:0]  upd_hist;
  logic        upd_ready;
  logic        commit;
  logic        flush;

  modport master (
    output upd_valid, upd_pc, upd_ataken, upd_misp, upd_hist, commit, flush,
    input  upd_ready
  );
  modport slave (
    input  upd_valid, upd_pc, upd_ataken, upd_misp, upd_hist, commit, flush,
    output upd_ready
  );
endinterface

interface exu_bp_bht_if #(
  parameter int IDX_W = 8
);
  logic             bht_wr_valid;
  logic             bht_wr_ready;
  logic [IDX_W-1:0] bht_wr_idx;
  logic [1:0]       bht_wr_data;

  modport master (
    output bht_wr_valid, bht_wr_idx, bht_wr_data,
    input  bht_wr_ready
  );
  modport slave (
    input  bht_wr_valid, bht_wr_idx, bht_wr_data,
    output bht_wr_ready
  );
endinterface

// File: rtl/exu_bp_upd_ctl_fifo.sv
// Three-pointer speculative FIFO: wr (next free), cm (oldest uncommitted), rd (head).
// Entries between rd and cm are committed and drainable; cm..wr are speculative.
module exu_bp_upd_ctl_fifo
  import exu_bp_upd_ctl_pkg::*;
#(
  parameter int DEPTH = BP_Q_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enq_i,
  input  bp_upd_pkt_t enq_pkt_i,
  input  logic        commit_i,
  input  logic        flush_i,
  input  logic        deq_i,
  output logic        full_o,
  output logic        cm_empty_o,
  output logic        head_vld_o,
  output bp_upd_pkt_t head_pkt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);

  bp_upd_pkt_t mem_q [DEPTH];
  logic [PW:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  logic        commit_ok, deq_ok, wr_en;

  assign full_o     = (wr_q - rd_q) == DEPTH_P;
  assign cm_empty_o = (cm_q == wr_q);
  assign head_vld_o = (rd_q != cm_q);
  // Zero the head when nothing is committed so the write port idles at 0.
  assign head_pkt_o = head_vld_o ? mem_q[rd_q[PW-1:0]] : '0;

  always_comb begin
    commit_ok = commit_i & ~cm_empty_o;
    deq_ok    = deq_i & head_vld_o;
    wr_en     = enq_i & ~full_o & ~flush_i;
    cm_d      = cm_q + {{PW{1'b0}}, commit_ok};
    rd_d      = rd_q + {{PW{1'b0}}, deq_ok};
    wr_d      = flush_i ? cm_d : (wr_q + {{PW{1'b0}}, wr_en});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      cm_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      cm_q <= cm_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[PW-1:0]] <= enq_pkt_i;
    end
  end

endmodule

// File: rtl/exu_bp_upd_ctl.sv
// Branch-predictor update queue: holds resolved branches until commit/flush and drains
// committed ones in order to the BHT, counting committed mispredicts.
module exu_bp_upd_ctl
  import exu_bp_upd_ctl_pkg::*;
#(
  parameter int DEPTH = BP_Q_DEPTH,
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  exu_bp_upd_if.slave       upd,
  exu_bp_bht_if.master      bht,
  output logic [CNT_W-1:0]  misp_cnt_o,
  output logic              ovf_err_o
);

  bp_upd_pkt_t      enq_pkt, head_pkt;
  logic             full, cm_empty, head_vld, enq, xfer;
  logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;
  logic             ovf_err_q, ovf_err_d;
  logic             unused_ataken;

  assign enq_pkt = '{pc: upd.upd_pc, ataken: upd.upd_ataken, misp: upd.upd_misp, hist: upd.upd_hist};
  // A same-cycle flush kills the incoming branch since it is younger than anything kept.
  assign enq  = upd.upd_valid & ~full & ~upd.flush;
  assign xfer = head_vld & bht.bht_wr_ready;

  exu_bp_upd_ctl_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (enq),
    .enq_pkt_i  (enq_pkt),
    .commit_i   (upd.commit),
    .flush_i    (upd.flush),
    .deq_i      (xfer),
    .full_o     (full),
    .cm_empty_o (cm_empty),
    .head_vld_o (head_vld),
    .head_pkt_o (head_pkt)
  );

  assign upd.upd_ready    = ~full;
  assign bht.bht_wr_valid = head_vld;
  assign bht.bht_wr_idx   = IDX_W'(bht_hash(head_pkt.pc, IDX_W));
  assign bht.bht_wr_data  = head_pkt.hist;
  assign unused_ataken    = head_pkt.ataken;

  always_comb begin
    misp_cnt_d = misp_cnt_q;
    if (xfer && head_pkt.misp && !(&misp_cnt_q)) begin
      misp_cnt_d = misp_cnt_q + CNT_W'(1);
    end
    ovf_err_d = ovf_err_q | (upd.upd_valid & full) | (upd.commit & cm_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misp_cnt_q <= '0;
      ovf_err_q  <= 1'b0;
    end else begin
      misp_cnt_q <= misp_cnt_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign misp_cnt_o = misp_cnt_q;
  assign ovf_err_o  = ovf_err_q;

endmodule

// File: tb/tb_exu_bp_upd_ctl.sv
// Directed bench for exu_bp_upd_ctl with a queue-based reference model checked every cycle.
module tb_exu_bp_upd_ctl;
  import exu_bp_upd_ctl_pkg::*;

  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int CNT_W = 16;
  localparam int unsigned MAXC = (32'd1 << CNT_W) - 32'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_bp_upd_if upd_bus ();
  exu_bp_bht_if #(.IDX_W(IDX_W)) bht_bus ();
  logic [CNT_W-1:0] misp_cnt;
  logic             ovf_err;

  exu_bp_upd_ctl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd        (upd_bus),
    .bht        (bht_bus),
    .misp_cnt_o (misp_cnt),
    .ovf_err_o  (ovf_err)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: committed entries are the first m_ncm elements of mq.
  typedef struct {
    int unsigned pc;
    bit          misp;
    bit [1:0]    hist;
  } ent_t;

  ent_t        mq[$];
  int          m_ncm = 0;
  int unsigned m_misp = 0;
  bit          m_ovf = 1'b0;

  function automatic int unsigned m_hash(input int unsigned pcv);
    return (pcv ^ (pcv >> IDX_W)) % (32'd1 << IDX_W);
  endfunction

  always @(posedge clk) begin : model
    int sz;
    bit full, xfer, cok;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_ncm  = 0;
      m_misp = 0;
      m_ovf  = 1'b0;
    end else begin
      sz   = mq.size();
      full = (sz == DEPTH);
      xfer = (m_ncm > 0) && bht_bus.bht_wr_ready;
      cok  = upd_bus.commit && (sz > m_ncm);
      if (upd_bus.upd_valid && full) m_ovf = 1'b1;
      if (upd_bus.commit && sz == m_ncm) m_ovf = 1'b1;
      if (xfer) begin
        if (mq[0].misp && m_misp != MAXC) m_misp++;
        void'(mq.pop_front());
        m_ncm--;
      end
      if (cok) m_ncm++;
      if (upd_bus.flush) begin
        while (mq.size() > m_ncm) void'(mq.pop_back());
      end else if (upd_bus.upd_valid && !full) begin
        e.pc   = 32'(upd_bus.upd_pc);
        e.misp = upd_bus.upd_misp;
        e.hist = upd_bus.upd_hist;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit exp_vld;
    if (chk_en) begin
      exp_vld = (m_ncm > 0);
      chk("upd_ready", 32'(upd_bus.upd_ready), 32'(mq.size() != DEPTH));
      chk("bht_wr_valid", 32'(bht_bus.bht_wr_valid), 32'(exp_vld));
      chk("bht_wr_idx", 32'(bht_bus.bht_wr_idx), exp_vld ? m_hash(mq[0].pc) : 32'd0);
      chk("bht_wr_data", 32'(bht_bus.bht_wr_data), exp_vld ? 32'(mq[0].hist) : 32'd0);
      chk("misp_cnt", 32'(misp_cnt), m_misp);
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    end
  end

  int          wr_cnt = 0;
  logic [31:0] last_idx = '0;
  always @(posedge clk) begin
    if (!rst && bht_bus.bht_wr_valid && bht_bus.bht_wr_ready) begin
      wr_cnt++;
      last_idx = 32'(bht_bus.bht_wr_idx);
    end
  end

  // Drive one cycle of inputs, then return at the following negedge.
  task automatic step(input bit v, input int unsigned pc, input bit misp, input bit [1:0] hist,
                      input bit cm, input bit fl, input bit rdy);
    upd_bus.upd_valid  = v;
    upd_bus.upd_pc     = 31'(pc);
    upd_bus.upd_ataken = hist[1];
    upd_bus.upd_misp   = misp;
    upd_bus.upd_hist   = hist;
    upd_bus.commit     = cm;
    upd_bus.flush      = fl;
    bht_bus.bht_wr_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(upd_bus.upd_ready), 32'd1);
    chk({tag, "_valid"}, 32'(bht_bus.bht_wr_valid), 32'd0);
    chk({tag, "_idx"}, 32'(bht_bus.bht_wr_idx), 32'd0);
    chk({tag, "_data"}, 32'(bht_bus.bht_wr_data), 32'd0);
    chk({tag, "_misp"}, 32'(misp_cnt), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
  endtask

  int w0;

  initial begin
    upd_bus.upd_valid = 1'b0; upd_bus.upd_pc = '0; upd_bus.upd_ataken = 1'b0;
    upd_bus.upd_misp = 1'b0; upd_bus.upd_hist = '0; upd_bus.commit = 1'b0;
    upd_bus.flush = 1'b0; bht_bus.bht_wr_ready = 1'b0;

    // Reset values, then single enqueue -> commit -> one write
    do_reset();
    chk_en = 1'b1;
    chk_reset("rst0");
    w0 = wr_cnt;
    step(1'b1, 32'h800, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("t1_no_early_valid", 32'(bht_bus.bht_wr_valid), 32'd0);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("t1_valid", 32'(bht_bus.bht_wr_valid), 32'd1);
    chk("t1_idx", 32'(bht_bus.bht_wr_idx), 32'h08);
    chk("t1_data", 32'(bht_bus.bht_wr_data), 32'h2);
    idle(1'b1);
    chk("t1_valid_drop", 32'(bht_bus.bht_wr_valid), 32'd0);
    chk("t1_writes", 32'(wr_cnt - w0), 32'd1);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("t1_commit_empty_ovf", 32'(ovf_err), 32'd1);

    // Three enqueued, one committed, flush -> one write; next enqueue reuses slot
    do_reset();
    w0 = wr_cnt;
    step(1'b1, 32'h100, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h200, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h300, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t2_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t2_idx", last_idx, 32'h01);
    step(1'b1, 32'h1234, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t2_writes_after", 32'(wr_cnt - w0), 32'd2);
    chk("t2_idx_after", last_idx, 32'h26);

    // Fill, overflow attempt, commit+drain frees a slot
    do_reset();
    step(1'b1, 32'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("t3_full", 32'(upd_bus.upd_ready), 32'd0);
    chk("t3_ovf_pre", 32'(ovf_err), 32'd0);
    step(1'b1, 32'h55, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf", 32'(ovf_err), 32'd1);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("t3_still_full", 32'(upd_bus.upd_ready), 32'd0);
    idle(1'b1);
    chk("t3_ready_back", 32'(upd_bus.upd_ready), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Commit + flush + enqueue together with two uncommitted entries
    do_reset();
    w0 = wr_cnt;
    step(1'b1, 32'hA5C3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0F0F, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h7777, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t4_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t4_idx", last_idx, 32'h66);
    chk("t4_empty", 32'(bht_bus.bht_wr_valid), 32'd0);

    // BHT stall with two committed entries, then back-to-back drain
    do_reset();
    step(1'b1, 32'h4321, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0055, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("t5_stall_idx", 32'(bht_bus.bht_wr_idx), 32'h62);
      chk("t5_stall_data", 32'(bht_bus.bht_wr_data), 32'h3);
    end
    idle(1'b1);
    chk("t5_second_valid", 32'(bht_bus.bht_wr_valid), 32'd1);
    chk("t5_second_idx", 32'(bht_bus.bht_wr_idx), 32'h55);
    chk("t5_misp_mid", 32'(misp_cnt), 32'd1);
    idle(1'b1);
    chk("t5_drained", 32'(bht_bus.bht_wr_valid), 32'd0);
    chk("t5_misp", 32'(misp_cnt), 32'd1);

    // Stream mispredicts up to 0xFFFE, then three more must saturate
    do_reset();
    step(1'b1, 32'h0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 65534; i++) step(1'b1, 32'(i), 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t6_near_sat", 32'(misp_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(16'hBEE0 + i), 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t6_sat", 32'(misp_cnt), 32'hFFFF);

    // Reset with the queue half full
    do_reset();
    step(1'b1, 32'h3C3C, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5A5A, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("t7_pre_valid", 32'(bht_bus.bht_wr_valid), 32'd1);
    w0 = wr_cnt;
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    chk_reset("t7");
    chk("t7_no_write", 32'(wr_cnt - w0), 32'd0);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exu_bp_upd_ctl.md
# exu_bp_upd_ctl

Branch-predictor update queue on the consuming side of the EXU branch-resolution path. It accepts one resolved-branch packet per cycle from the ALU stage (PC, actual direction, mispredict, new 2-bit history) and holds it as speculative until the pipeline commits or flushes it. Committed packets drain in order to the BHT write port over a valid/ready handshake. The block sits between exu_alu_ctl's resolved-predict outputs and the IFU branch-history table.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- IDX_W, 8: BHT index width.
- CNT_W, 16: mispredict counter width.

Ports:
- clk  in  1  top-level clock.
- rst  in  1  reset, synchronous, active-high.
- upd_valid  in  1  resolved conditional branch this cycle.
- upd_pc  in  31  branch PC[31:1].
- upd_ataken  in  1  actual taken.
- upd_misp  in  1  mispredicted.
- upd_hist  in  2  new counter value.
- upd_ready  out  1  space available; combinational from the registered count.
- commit  in  1  oldest uncommitted entry retires.
- flush  in  1  discard all uncommitted entries.
- bht_wr_valid  out  1  head entry committed and ready to write.
- bht_wr_ready  in  1  BHT accepts the write.
- bht_wr_idx  out  IDX_W  hashed index.
- bht_wr_data  out  2  counter value.
- misp_cnt  out  CNT_W  committed mispredicts, saturating.
- ovf_err  out  1  sticky protocol-violation flag.

## Operation
- Storage: circular buffer of DEPTH entries {pc, ataken, misp, hist}.
- Three pointers, each log2(DEPTH)+1 bits wide, wrap with a phase bit:
  - wr_ptr: next free entry.
  - cm_ptr: oldest uncommitted entry.
  - rd_ptr: head.
- Invariant: rd_ptr ≤ cm_ptr ≤ wr_ptr, in modulo order.
- Enqueue: upd_valid & upd_ready & ~flush writes entry[wr_ptr] and increments wr_ptr.
- upd_ready = (wr_ptr − rd_ptr) != DEPTH.
- Upstream must freeze rather than present upd_valid while upd_ready=0. Such an input is ignored and sets ovf_err, which only rst clears.
- Commit: commit & (cm_ptr != wr_ptr) increments cm_ptr. A commit with no uncommitted entries is ignored and sets ovf_err.
- Flush: wr_ptr ← cm_ptr after any same-cycle commit. An enqueue in the same cycle is dropped because the incoming branch is younger.
- Drain: bht_wr_valid = (rd_ptr != cm_ptr). A transfer occurs when bht_wr_valid & bht_wr_ready, and rd_ptr increments.
  - bht_wr_idx = pc[IDX_W:1] ^ pc[2*IDX_W:IDX_W+1].
  - bht_wr_data = hist.
- misp_cnt increments on each transfer whose entry has misp=1, saturating at all-ones.
- Simultaneous enqueue, commit and drain in one cycle are all legal and independent.
- The full check uses the pre-drain count, so no same-cycle bypass of a full queue.

## Timing
- Reset: all pointers 0, upd_ready=1, bht_wr_valid=0, bht_wr_idx=0, bht_wr_data=0, misp_cnt=0, ovf_err=0. Queue contents are don't-care.
- Enqueue at cycle N, commit at cycle M ≥ N: bht_wr_valid is first high in M+1, when the entry is at the head.
- Commit in the same cycle as enqueue commits only an already-queued entry, never the incoming one.
- Outputs are driven from registered state only. There is no combinational path from upd_* or commit to bht_wr_*.
- While the BHT stalls, the head entry and its data stay stable until accepted.
- Back-to-back drain reaches 1 entry per cycle when bht_wr_ready is held high.
- rst during operation empties the queue on the next edge, with no partial writes.

## Structure
- Shared package holds:
  - typedef bp_upd_pkt_t {pc[31:1], ataken, misp, hist[1:0]}.
  - function bht_hash(pc, IDX_W).
  - BP_Q_DEPTH default constant.
- Natural sub-module: exu_bp_upd_fifo, the three-pointer speculative FIFO (storage, wr/cm/rd pointers, full/committed-empty flags).
- The top level adds the hash, the mispredict counter and ovf_err.

## Test plan
- Enqueue pc=0x1000>>1 with hist=2'b10, commit 1 cycle later, bht_wr_ready=1 → bht_wr_valid high for exactly 1 cycle 1 cycle after commit; idx = hash(pc); data = 2'b10.
- Enqueue 3 entries, commit 1, flush → exactly 1 BHT write. The next enqueue lands in the slot of the second entry.
- Fill 4 entries → upd_ready=0. Extra upd_valid sets ovf_err and nothing is written. Commit and drain 1 → upd_ready=1 the next cycle.
- Commit, flush and upd_valid in the same cycle with 2 uncommitted entries → 1 committed, 1 discarded, incoming dropped.
- Hold bht_wr_ready=0 for 5 cycles with 2 committed entries → head idx/data stable. Release → 2 writes on consecutive cycles; misp_cnt += number of entries with misp=1.
- Preload misp_cnt near saturation (0xFFFE), drain 3 mispredicts → misp_cnt stays 0xFFFF.
- Assert rst with the queue half full → all outputs at reset values the next cycle.
